// File: rtl/sdram_frame_buf_ctrl.sv
// SDRAM burst scheduler and frame-buffer address generator: round-robin write/read
// arbitration over NUM_BUF frame buffers selected by the bank field.
module sdram_frame_buf_ctrl #(
    parameter int ADDR_W        = 24,
    parameter int BANK_W        = 2,
    parameter int LEN_W         = 10,
    parameter int CNT_W         = 10,
    parameter int NUM_BUF       = 2,
    parameter int RD_FIFO_DEPTH = 1024
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     init_end,
    input  logic                     multibuf_en,
    input  logic                     wr_rst,
    input  logic                     rd_rst,
    input  logic [ADDR_W-BANK_W-1:0] wr_b_addr,
    input  logic [ADDR_W-BANK_W-1:0] wr_e_addr,
    input  logic [LEN_W-1:0]         wr_burst_len,
    input  logic [ADDR_W-BANK_W-1:0] rd_b_addr,
    input  logic [ADDR_W-BANK_W-1:0] rd_e_addr,
    input  logic [LEN_W-1:0]         rd_burst_len,
    input  logic                     read_valid,
    input  logic [CNT_W-1:0]         wr_fifo_num,
    input  logic [CNT_W-1:0]         rd_fifo_num,
    input  logic                     sdram_wr_ack,
    input  logic                     sdram_rd_ack,
    output logic                     sdram_wr_req,
    output logic [ADDR_W-1:0]        sdram_wr_addr,
    output logic                     sdram_rd_req,
    output logic [ADDR_W-1:0]        sdram_rd_addr,
    output logic [BANK_W-1:0]        wr_buf_idx,
    output logic [BANK_W-1:0]        rd_buf_idx,
    output logic                     wr_frame_done,
    output logic                     rd_frame_done
);

    localparam int OFF_W = ADDR_W - BANK_W;

    typedef logic [OFF_W-1:0]  off_t;
    typedef logic [OFF_W:0]    off_ext_t;
    typedef logic [BANK_W-1:0] bank_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_BUSY,
        RD_REQ,
        RD_BUSY
    } state_t;

    state_t state;
    logic   init_end_d;
    logic   wr_ack_d;
    logic   rd_ack_d;
    logic   last_grant_rd;
    off_t   wr_off;
    off_t   rd_off;
    bank_t  wr_buf;
    bank_t  rd_buf;
    bank_t  last_done;
    bank_t  wr_buf_nxt;
    logic   done_vld;
    logic   wr_skip;
    logic   rd_skip;

    logic wr_ok, rd_ok;
    logic wr_rise, wr_fall, rd_rise, rd_fall;
    logic wr_last, rd_last;
    logic wr_adv, rd_adv, wr_end, rd_end;

    function automatic bank_t buf_step(input bank_t i);
        return (i == bank_t'(NUM_BUF - 1)) ? '0 : i + 1'b1;
    endfunction

    assign wr_ok = 32'(wr_fifo_num) >= 32'(wr_burst_len);
    assign rd_ok = read_valid
                && (32'(rd_fifo_num) + 32'(rd_burst_len) <= 32'(RD_FIFO_DEPTH))
                && (done_vld || !multibuf_en);

    assign wr_rise = !wr_ack_d && sdram_wr_ack;
    assign wr_fall = wr_ack_d && !sdram_wr_ack;
    assign rd_rise = !rd_ack_d && sdram_rd_ack;
    assign rd_fall = rd_ack_d && !sdram_rd_ack;

    // One extra bit so offset + len cannot wrap past the end address.
    assign wr_last = (off_ext_t'(wr_off) + off_ext_t'(wr_burst_len)) >= off_ext_t'(wr_e_addr);
    assign rd_last = (off_ext_t'(rd_off) + off_ext_t'(rd_burst_len)) >= off_ext_t'(rd_e_addr);

    assign wr_adv = (state == WR_BUSY) && wr_fall && !wr_rst && !wr_skip;
    assign rd_adv = (state == RD_BUSY) && rd_fall && !rd_rst && !rd_skip;
    assign wr_end = wr_adv && wr_last;
    assign rd_end = rd_adv && rd_last;

    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        wr_buf_nxt = '0;
        if (NUM_BUF == 2) begin
            wr_buf_nxt = wr_buf ^ bank_t'(1);
        end else begin
            wr_buf_nxt = buf_step(wr_buf);
            if (wr_buf_nxt == rd_buf)
                wr_buf_nxt = buf_step(wr_buf_nxt);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            last_grant_rd <= 1'b1;
            init_end_d    <= 1'b0;
            wr_ack_d      <= 1'b0;
            rd_ack_d      <= 1'b0;
            sdram_wr_req  <= 1'b0;
            sdram_rd_req  <= 1'b0;
        end else begin
            init_end_d <= init_end;
            wr_ack_d   <= sdram_wr_ack;
            rd_ack_d   <= sdram_rd_ack;
            case (state)
                IDLE: begin
                    if (init_end_d) begin
                        if (wr_ok && (!rd_ok || last_grant_rd)) begin
                            state         <= WR_REQ;
                            sdram_wr_req  <= 1'b1;
                            last_grant_rd <= 1'b0;
                        end else if (rd_ok) begin
                            state         <= RD_REQ;
                            sdram_rd_req  <= 1'b1;
                            last_grant_rd <= 1'b1;
                        end
                    end
                end
                WR_REQ: begin
                    if (wr_rise) begin
                        state        <= WR_BUSY;
                        sdram_wr_req <= 1'b0;
                    end
                end
                WR_BUSY: if (wr_fall) state <= IDLE;
                RD_REQ: begin
                    if (rd_rise) begin
                        state        <= RD_BUSY;
                        sdram_rd_req <= 1'b0;
                    end
                end
                RD_BUSY: if (rd_fall) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_off        <= '0;
            rd_off        <= '0;
            wr_buf        <= '0;
            rd_buf        <= '0;
            last_done     <= '0;
            done_vld      <= 1'b0;
            wr_skip       <= 1'b0;
            rd_skip       <= 1'b0;
            wr_frame_done <= 1'b0;
            rd_frame_done <= 1'b0;
        end else begin
            wr_frame_done <= wr_end;
            rd_frame_done <= rd_end;

            if (wr_rst)
                wr_off <= wr_b_addr;
            else if (wr_adv)
                wr_off <= wr_last ? wr_b_addr : wr_off + off_t'(wr_burst_len);

            if (rd_rst)
                rd_off <= rd_b_addr;
            else if (rd_adv)
                rd_off <= rd_last ? rd_b_addr : rd_off + off_t'(rd_burst_len);

            // A restart during an in-flight burst suppresses that burst's offset advance.
            if (state == WR_BUSY && wr_fall)
                wr_skip <= 1'b0;
            else if (wr_rst && (state == WR_REQ || state == WR_BUSY))
                wr_skip <= 1'b1;

            if (state == RD_BUSY && rd_fall)
                rd_skip <= 1'b0;
            else if (rd_rst && (state == RD_REQ || state == RD_BUSY))
                rd_skip <= 1'b1;

            if (!multibuf_en || wr_rst)
                wr_buf <= '0;
            else if (wr_end)
                wr_buf <= wr_buf_nxt;

            if (multibuf_en && wr_end)
                last_done <= wr_buf;

            if (wr_rst)
                done_vld <= 1'b0;
            else if (multibuf_en && wr_end)
                done_vld <= 1'b1;

            // Reader follows the newest finished frame, else repeats its own.
            if (!multibuf_en)
                rd_buf <= '0;
            else if ((rd_rst || rd_end) && done_vld)
                rd_buf <= last_done;
        end
    end

    assign sdram_wr_addr = {wr_buf, wr_off};
    assign sdram_rd_addr = {rd_buf, rd_off};
    assign wr_buf_idx    = wr_buf;
    assign rd_buf_idx    = rd_buf;

endmodule

// File: tb/tb_sdram_frame_buf_ctrl.sv
// Bench for sdram_frame_buf_ctrl: NUM_BUF=2 and NUM_BUF=3 instances share stimulus and
// are checked against a transaction-level model of offsets, buffers and arbitration.
module tb_sdram_frame_buf_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        init_end = 1'b0;
    logic        multibuf_en = 1'b0;
    logic        wr_rst = 1'b0;
    logic        rd_rst = 1'b0;
    logic [21:0] wr_b = '0, wr_e = '0, rd_b = '0, rd_e = '0;
    logic [9:0]  wr_len = '0, rd_len = '0;
    logic        read_valid = 1'b0;
    logic [9:0]  wr_fifo_num = '0, rd_fifo_num = '0;
    logic        wr_ack = 1'b0, rd_ack = 1'b0;

    logic        wr_req [2];
    logic        rd_req [2];
    logic [23:0] wr_addr [2];
    logic [23:0] rd_addr [2];
    logic [1:0]  wr_idx [2];
    logic [1:0]  rd_idx [2];
    logic        wr_done [2];
    logic        rd_done [2];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state; index 0 tracks NUM_BUF=2, index 1 tracks NUM_BUF=3.
    logic [21:0] m_wr_off, m_rd_off;
    bit          m_last_rd;
    int          m_wr_buf [2];
    int          m_rd_buf [2];
    int          m_last_done [2];
    bit          m_dvld;

    always #5 sys_clk = ~sys_clk;

    sdram_frame_buf_ctrl #(.NUM_BUF(2)) u_dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .multibuf_en(multibuf_en),
        .wr_rst(wr_rst), .rd_rst(rd_rst),
        .wr_b_addr(wr_b), .wr_e_addr(wr_e), .wr_burst_len(wr_len),
        .rd_b_addr(rd_b), .rd_e_addr(rd_e), .rd_burst_len(rd_len),
        .read_valid(read_valid), .wr_fifo_num(wr_fifo_num), .rd_fifo_num(rd_fifo_num),
        .sdram_wr_ack(wr_ack), .sdram_rd_ack(rd_ack),
        .sdram_wr_req(wr_req[0]), .sdram_wr_addr(wr_addr[0]),
        .sdram_rd_req(rd_req[0]), .sdram_rd_addr(rd_addr[0]),
        .wr_buf_idx(wr_idx[0]), .rd_buf_idx(rd_idx[0]),
        .wr_frame_done(wr_done[0]), .rd_frame_done(rd_done[0])
    );

    sdram_frame_buf_ctrl #(.NUM_BUF(3)) u_dut3 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .multibuf_en(multibuf_en),
        .wr_rst(wr_rst), .rd_rst(rd_rst),
        .wr_b_addr(wr_b), .wr_e_addr(wr_e), .wr_burst_len(wr_len),
        .rd_b_addr(rd_b), .rd_e_addr(rd_e), .rd_burst_len(rd_len),
        .read_valid(read_valid), .wr_fifo_num(wr_fifo_num), .rd_fifo_num(rd_fifo_num),
        .sdram_wr_ack(wr_ack), .sdram_rd_ack(rd_ack),
        .sdram_wr_req(wr_req[1]), .sdram_wr_addr(wr_addr[1]),
        .sdram_rd_req(rd_req[1]), .sdram_rd_addr(rd_addr[1]),
        .wr_buf_idx(wr_idx[1]), .rd_buf_idx(rd_idx[1]),
        .wr_frame_done(wr_done[1]), .rd_frame_done(rd_done[1])
    );

    task automatic model_reset();
        m_wr_off  = '0;
        m_rd_off  = '0;
        m_last_rd = 1'b1;
        m_dvld    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_wr_buf[k]    = 0;
            m_rd_buf[k]    = 0;
            m_last_done[k] = 0;
        end
    endtask

    // 0 = no grant, 1 = write, 2 = read
    function automatic int exp_grant();
        bit w, r;
        w = int'(wr_fifo_num) >= int'(wr_len);
        r = read_valid && (int'(rd_fifo_num) + int'(rd_len) <= 1024) && (m_dvld || !multibuf_en);
        if (w && r) return m_last_rd ? 1 : 2;
        if (w) return 1;
        if (r) return 2;
        return 0;
    endfunction

    task automatic model_finish(input bit is_wr, output bit frame_end);
        int n, nxt;
        if (is_wr) begin
            frame_end = int'(m_wr_off) + int'(wr_len) >= int'(wr_e);
            if (!frame_end) begin
                m_wr_off = m_wr_off + 22'(wr_len);
            end else begin
                m_wr_off = wr_b;
                if (multibuf_en) begin
                    m_dvld = 1'b1;
                    for (int k = 0; k < 2; k++) begin
                        n = k + 2;
                        m_last_done[k] = m_wr_buf[k];
                        nxt = (m_wr_buf[k] + 1) % n;
                        if (n > 2 && nxt == m_rd_buf[k]) nxt = (nxt + 1) % n;
                        m_wr_buf[k] = nxt;
                    end
                end
            end
        end else begin
            frame_end = int'(m_rd_off) + int'(rd_len) >= int'(rd_e);
            if (!frame_end) begin
                m_rd_off = m_rd_off + 22'(rd_len);
            end else begin
                m_rd_off = rd_b;
                if (multibuf_en && m_dvld)
                    for (int k = 0; k < 2; k++) m_rd_buf[k] = m_last_done[k];
            end
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        wr_ack  = 1'b0;
        rd_ack  = 1'b0;
        wr_rst  = 1'b0;
        rd_rst  = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
    endtask

    // Plays the SDRAM engine for one burst and checks it against the model.
    task automatic serve(output int side, output logic [23:0] addr, output bit done);
        int          t, exp_side, hold;
        bit          fe;
        logic [23:0] exp_addr [2];
        logic [23:0] got;
        exp_side = exp_grant();
        t = 0;
        while (wr_req[0] !== 1'b1 && rd_req[0] !== 1'b1 && t < 40) begin
            @(negedge sys_clk);
            t++;
        end
        side = (wr_req[0] === 1'b1) ? 1 : ((rd_req[0] === 1'b1) ? 2 : 0);
        addr = '0;
        done = 1'b0;
        n_checks++;
        if (side != exp_side) $display("FAIL grant: got side %0d, expected %0d", side, exp_side);
        else n_pass++;
        if (side == 0) return;
        n_checks++;
        if (wr_req[0] === 1'b1 && rd_req[0] === 1'b1) $display("FAIL one_req: both requests high");
        else if (wr_req[1] !== wr_req[0] || rd_req[1] !== rd_req[0])
            $display("FAIL req_agree: nb3 wr=%b rd=%b, nb2 wr=%b rd=%b", wr_req[1], rd_req[1], wr_req[0], rd_req[0]);
        else n_pass++;
        m_last_rd = (side == 2);
        for (int k = 0; k < 2; k++) begin
            exp_addr[k] = (side == 1) ? {2'(m_wr_buf[k]), m_wr_off} : {2'(m_rd_buf[k]), m_rd_off};
            got = (side == 1) ? wr_addr[k] : rd_addr[k];
            n_checks++;
            if (got !== exp_addr[k]) $display("FAIL addr[nb%0d]: got %h, expected %h", k + 2, got, exp_addr[k]);
            else n_pass++;
        end
        addr = (side == 1) ? wr_addr[0] : rd_addr[0];
        if (side == 1) wr_ack = 1'b1; else rd_ack = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if ({wr_req[0], rd_req[0], wr_req[1], rd_req[1]} !== 4'b0000)
            $display("FAIL req_drop: reqs %b%b%b%b, expected 0000", wr_req[0], rd_req[0], wr_req[1], rd_req[1]);
        else n_pass++;
        hold = $urandom_range(0, 3);
        repeat (hold) @(negedge sys_clk);
        got = (side == 1) ? wr_addr[0] : rd_addr[0];
        n_checks++;
        if (got !== exp_addr[0]) $display("FAIL addr_hold: got %h, expected %h", got, exp_addr[0]);
        else n_pass++;
        if (side == 1) wr_ack = 1'b0; else rd_ack = 1'b0;
        @(negedge sys_clk);
        model_finish(side == 1, fe);
        done = (side == 1) ? wr_done[0] : rd_done[0];
        n_checks++;
        if ({wr_done[0], rd_done[0], wr_done[1], rd_done[1]} !==
            ((side == 1) ? {fe, 1'b0, fe, 1'b0} : {1'b0, fe, 1'b0, fe}))
            $display("FAIL frame_done: got %b%b%b%b, frame end expected %b on side %0d",
                     wr_done[0], rd_done[0], wr_done[1], rd_done[1], fe, side);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (int'(wr_idx[k]) != m_wr_buf[k] || int'(rd_idx[k]) != m_rd_buf[k])
                $display("FAIL buf_idx[nb%0d]: got wr=%0d rd=%0d, expected wr=%0d rd=%0d",
                         k + 2, wr_idx[k], rd_idx[k], m_wr_buf[k], m_rd_buf[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({wr_req[k], rd_req[k], wr_addr[k], rd_addr[k], wr_idx[k], rd_idx[k], wr_done[k], rd_done[k]} !== '0)
                $display("FAIL reset_outputs[nb%0d]: wr_addr=%h rd_addr=%h req=%b%b, expected all 0",
                         k + 2, wr_addr[k], rd_addr[k], wr_req[k], rd_req[k]);
            else n_pass++;
        end
    endtask

    task automatic test_single_buffer();
        int s; logic [23:0] a; bit d;
        init_end = 1'b1; multibuf_en = 1'b0; read_valid = 1'b0;
        wr_len = 10'd256; wr_b = 22'd0; wr_e = 22'd1024; wr_fifo_num = 10'd300;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            serve(s, a, d);
            n_checks++;
            if (a !== 24'((i % 4) * 256) || d !== (i == 3))
                $display("FAIL single_buf[%0d]: got addr %h done %b, expected addr %h done %b",
                         i, a, d, 24'((i % 4) * 256), (i == 3));
            else n_pass++;
        end
    endtask

    task automatic test_pingpong();
        int s; logic [23:0] a; bit d;
        multibuf_en = 1'b1; read_valid = 1'b0;
        wr_len = 10'd256; wr_b = 22'd0; wr_e = 22'd1024; wr_fifo_num = 10'd300;
        rd_len = 10'd256; rd_b = 22'd0; rd_e = 22'd512; rd_fifo_num = 10'd0;
        do_reset();
        repeat (4) serve(s, a, d);
        serve(s, a, d);
        n_checks++;
        if (a !== 24'h400000) $display("FAIL pingpong_wr: got %h, expected 400000", a);
        else n_pass++;
        wr_fifo_num = 10'd0; read_valid = 1'b1;
        serve(s, a, d);
        n_checks++;
        if (s != 2 || a[23:22] !== 2'd0) $display("FAIL pingpong_rd: side %0d bank %0d, expected read of bank 0", s, a[23:22]);
        else n_pass++;
    endtask

    task automatic test_buf_skip();
        int s; logic [23:0] a; bit d;
        multibuf_en = 1'b1; read_valid = 1'b0;
        wr_len = 10'd256; wr_b = 22'd0; wr_e = 22'd256; wr_fifo_num = 10'd300;
        rd_len = 10'd256; rd_b = 22'd0; rd_e = 22'd256; rd_fifo_num = 10'd0;
        do_reset();
        repeat (2) serve(s, a, d);
        wr_fifo_num = 10'd0; read_valid = 1'b1;
        serve(s, a, d);
        wr_fifo_num = 10'd300; read_valid = 1'b0;
        repeat (2) serve(s, a, d);
        n_checks++;
        if (wr_idx[1] !== 2'd2 || rd_idx[1] !== 2'd1)
            $display("FAIL buf_skip: nb3 wr_buf %0d rd_buf %0d, expected 2 and 1", wr_idx[1], rd_idx[1]);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        int s; logic [23:0] a; bit d;
        multibuf_en = 1'b0; read_valid = 1'b1;
        wr_len = 10'd64; wr_b = 22'd0; wr_e = 22'd4096; wr_fifo_num = 10'd1023;
        rd_len = 10'd64; rd_b = 22'd0; rd_e = 22'd4096; rd_fifo_num = 10'd0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            serve(s, a, d);
            n_checks++;
            if (s != ((i % 2 == 0) ? 1 : 2)) $display("FAIL alternate[%0d]: got side %0d, expected %0d", i, s, (i % 2 == 0) ? 1 : 2);
            else n_pass++;
        end
    endtask

    task automatic test_init_gate();
        int s; logic [23:0] a; bit d; bit seen;
        init_end = 1'b0; multibuf_en = 1'b0; read_valid = 1'b0;
        wr_len = 10'd64; wr_b = 22'd0; wr_e = 22'd4096; wr_fifo_num = 10'd1023;
        do_reset();
        seen = 1'b0;
        repeat (10) begin
            @(negedge sys_clk);
            if (wr_req[0] === 1'b1 || rd_req[0] === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL init_hold: request seen, expected none while init_end=0");
        else n_pass++;
        init_end = 1'b1;
        @(negedge sys_clk);
        n_checks++;
        if (wr_req[0] !== 1'b0) $display("FAIL init_lag1: wr_req %b, expected 0", wr_req[0]);
        else n_pass++;
        @(negedge sys_clk);
        n_checks++;
        if (wr_req[0] !== 1'b1) $display("FAIL init_lag2: wr_req %b, expected 1", wr_req[0]);
        else n_pass++;
        serve(s, a, d);
    endtask

    task automatic test_wr_rst();
        int s, t; logic [23:0] a; bit d;
        multibuf_en = 1'b0; read_valid = 1'b0;
        wr_len = 10'd256; wr_b = 22'd0; wr_e = 22'd1024; wr_fifo_num = 10'd300;
        do_reset();
        repeat (2) serve(s, a, d);
        t = 0;
        while (wr_req[0] !== 1'b1 && t < 40) begin
            @(negedge sys_clk);
            t++;
        end
        n_checks++;
        if (wr_req[0] !== 1'b1 || wr_addr[0] !== 24'd512) $display("FAIL wr_rst_pre: req %b addr %h, expected 1 and 000200", wr_req[0], wr_addr[0]);
        else n_pass++;
        m_last_rd = 1'b0;
        wr_ack = 1'b1;
        @(negedge sys_clk);
        wr_rst = 1'b1;
        @(negedge sys_clk);
        wr_rst = 1'b0;
        n_checks++;
        if (wr_addr[0] !== 24'd0) $display("FAIL wr_rst_offset: got %h, expected 000000", wr_addr[0]);
        else n_pass++;
        wr_ack = 1'b0;
        @(negedge sys_clk);
        n_checks++;
        if (wr_done[0] !== 1'b0) $display("FAIL wr_rst_done: wr_frame_done %b, expected 0", wr_done[0]);
        else n_pass++;
        m_wr_off = wr_b;
        m_dvld   = 1'b0;
        serve(s, a, d);
        n_checks++;
        if (a !== 24'd0) $display("FAIL wr_rst_after: got %h, expected 000000", a);
        else n_pass++;
        serve(s, a, d);
    endtask

    task automatic test_rst_mid_read();
        int s, t; logic [23:0] a; bit d;
        multibuf_en = 1'b0; read_valid = 1'b1; wr_fifo_num = 10'd0;
        rd_len = 10'd64; rd_b = 22'd0; rd_e = 22'd1024; rd_fifo_num = 10'd0;
        do_reset();
        serve(s, a, d);
        t = 0;
        while (rd_req[0] !== 1'b1 && t < 40) begin
            @(negedge sys_clk);
            t++;
        end
        rd_ack = 1'b1;
        @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({wr_req[k], rd_req[k], wr_addr[k], rd_addr[k], wr_idx[k], rd_idx[k], wr_done[k], rd_done[k]} !== '0)
                $display("FAIL async_rst[nb%0d]: rd_addr=%h rd_req=%b, expected all outputs 0", k + 2, rd_addr[k], rd_req[k]);
            else n_pass++;
        end
        @(negedge sys_clk);
        rd_ack  = 1'b0;
        sys_rst = 1'b0;
        model_reset();
        @(negedge sys_clk);
        n_checks++;
        if (rd_req[0] !== 1'b0) $display("FAIL post_rst_idle: rd_req %b, expected 0", rd_req[0]);
        else n_pass++;
        serve(s, a, d);
        n_checks++;
        if (s != 2 || a !== 24'd0) $display("FAIL post_rst_read: side %0d addr %h, expected 2 and 000000", s, a);
        else n_pass++;
    endtask

    task automatic test_random();
        int s, r, g; logic [23:0] a; bit d;
        multibuf_en = 1'b1; init_end = 1'b1;
        wr_len = 10'(64 * $urandom_range(1, 4));
        rd_len = 10'(64 * $urandom_range(1, 4));
        wr_b = 22'($urandom_range(0, 63) * 64);
        rd_b = 22'($urandom_range(0, 63) * 64);
        wr_e = 22'(int'(wr_b) + int'(wr_len) * $urandom_range(1, 4) - $urandom_range(0, int'(wr_len) - 1));
        rd_e = 22'(int'(rd_b) + int'(rd_len) * $urandom_range(1, 4) - $urandom_range(0, int'(rd_len) - 1));
        wr_fifo_num = '0; read_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 1) begin
                wr_fifo_num = '0; read_valid = 1'b0;
                if (r == 0) wr_rst = 1'b1; else rd_rst = 1'b1;
                @(negedge sys_clk);
                wr_rst = 1'b0; rd_rst = 1'b0;
                if (r == 0) begin
                    m_wr_off = wr_b; m_dvld = 1'b0;
                    for (int k = 0; k < 2; k++) m_wr_buf[k] = 0;
                end else begin
                    m_rd_off = rd_b;
                    if (m_dvld) for (int k = 0; k < 2; k++) m_rd_buf[k] = m_last_done[k];
                end
            end else begin
                wr_fifo_num = 10'($urandom_range(0, 1023));
                rd_fifo_num = 10'($urandom_range(0, 1023));
                read_valid  = ($urandom_range(0, 3) != 0);
                g = exp_grant();
                if (g == 0) begin
                    repeat (3) @(negedge sys_clk);
                    n_checks++;
                    if (wr_req[0] !== 1'b0 || rd_req[0] !== 1'b0) $display("FAIL no_grant: req wr=%b rd=%b, expected none", wr_req[0], rd_req[0]);
                    else n_pass++;
                end else begin
                    serve(s, a, d);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_single_buffer();
        test_pingpong();
        test_buf_skip();
        test_arbitration();
        test_init_gate();
        test_wr_rst();
        test_rst_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
